// File: rtl/fetch_stage_ctrl.sv
// Fetch stage and IF/ID pipeline register: PC sequencing, sync imem addressing,
// and D-stage capture with bubble insertion on flush, redirect, boot and error.
//
// state | meaning
// BOOT  | first cycle after reset release, fetched word not yet valid
// RUN   | normal sequential fetch
// ERR   | halted after a misaligned redirect, left only through reset
module fetch_stage_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            branch_sig,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  output logic            fetch_err,
  output logic [31:0]     fetch_count
);

  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            err_set;
  logic            misaligned;
  logic            deliver;

  assign misaligned = branch_target[1:0] != 2'b00;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pcF;
    err_set   = 1'b0;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = ERR;
    endcase
    // Once halted, redirects are ignored so the error PC stays visible.
    if (state != ERR && branch_sig) begin
      if (misaligned) begin
        state_nxt = ERR;
        err_set   = 1'b1;
      end else begin
        pc_nxt = branch_target;
      end
    end else if (!stallF && state == RUN) begin
      pc_nxt = pcF + FOUR;
    end
  end

  assign imem_addr = reset ? pc_nxt : RESET_PC;
  assign deliver   = state == RUN && !branch_sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      pcF       <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pcF   <= pc_nxt;
      if (err_set) fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrD      <= NOP;
      pcD         <= '0;
      pc_plus4D   <= FOUR;
      validD      <= 1'b0;
      fetch_count <= '0;
    end else if (flushD || (!stallD && !deliver)) begin
      instrD    <= NOP;
      pcD       <= pcF;
      pc_plus4D <= pcF + FOUR;
      validD    <= 1'b0;
    end else if (!stallD) begin
      instrD      <= imem_rdata;
      pcD         <= pcF;
      pc_plus4D   <= pcF + FOUR;
      validD      <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
